// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: buffers samples in a circular delay line, streams one
// (sample, coefficient) pair per cycle into an external MAC and returns the sum.
module fir_tap_sequencer #(
  parameter int TAPS    = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 39,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              mac_en,
  output logic              mac_clear,
  output logic [DATA_W-1:0] mac_x,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(MAC_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [DATA_W-1:0] delay_r [TAPS];
  logic [DATA_W-1:0] coef_r  [TAPS];
  logic [ADDR_W-1:0] wp_r;
  logic [ADDR_W-1:0] newest_r;
  logic [ADDR_W-1:0] k_r;
  logic [CNT_W-1:0]  drain_cnt_r;

  logic              accept_s;
  logic              last_tap_s;
  logic              drain_done_s;
  logic              out_take_s;
  logic [ADDR_W-1:0] tap_idx_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] coef_sel_s;

  assign in_ready = (state_r == IDLE);

  // Next-state decode and operand selection for the tap loaded at the coming edge
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    last_tap_s   = 1'b0;
    drain_done_s = 1'b0;
    out_take_s   = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = in_valid;
        if (in_valid) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        last_tap_s = (k_r == LAST_TAP);
        if (k_r == LAST_TAP) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = ISSUE;
        end
      end
      DRAIN: begin
        drain_done_s = (drain_cnt_r == DRAIN_LAST);
        if (drain_cnt_r == DRAIN_LAST) begin
          next_state_s = OUTPUT;
        end else begin
          next_state_s = DRAIN;
        end
      end
      OUTPUT: begin
        out_take_s = out_ready;
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = OUTPUT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase

    // A coefficient written this cycle must already reach the next tap, so bypass it.
    if (accept_s) begin
      tap_idx_s = {ADDR_W{1'b0}};
    end else begin
      tap_idx_s = k_r + ADDR_W'(1);
    end
    rd_addr_s = newest_r - tap_idx_s;
    if (coef_we && (coef_addr == tap_idx_s)) begin
      coef_sel_s = coef_data;
    end else begin
      coef_sel_s = coef_r[tap_idx_s];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Coefficient bank, writable in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_r[i] <= {DATA_W{1'b0}};
      end
    end else if (coef_we) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

  // Circular delay line, written only on sample acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        delay_r[i] <= {DATA_W{1'b0}};
      end
    end else if (accept_s) begin
      delay_r[wp_r] <= in_sample;
    end
  end

  // Sequencing counters: write pointer, newest index, tap index, drain count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r        <= {ADDR_W{1'b0}};
      newest_r    <= {ADDR_W{1'b0}};
      k_r         <= {ADDR_W{1'b0}};
      drain_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            newest_r <= wp_r;
            k_r      <= {ADDR_W{1'b0}};
          end
        end
        ISSUE: begin
          k_r <= k_r + ADDR_W'(1);
          if (last_tap_s) begin
            wp_r        <= wp_r + ADDR_W'(1);
            drain_cnt_r <= {CNT_W{1'b0}};
          end
        end
        DRAIN: begin
          drain_cnt_r <= drain_cnt_r + CNT_W'(1);
        end
        OUTPUT: begin
          drain_cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          k_r <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Registered MAC drive and result handshake; tap k is loaded one edge ahead of use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en    <= 1'b0;
      mac_clear <= 1'b0;
      mac_x     <= {DATA_W{1'b0}};
      mac_b     <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {ACC_W{1'b0}};
    end else begin
      mac_en    <= 1'b0;
      mac_clear <= 1'b0;
      mac_x     <= {DATA_W{1'b0}};
      mac_b     <= {DATA_W{1'b0}};
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mac_en    <= 1'b1;
            mac_clear <= 1'b1;
            mac_x     <= in_sample;
            mac_b     <= coef_sel_s;
          end
        end
        ISSUE: begin
          if (!last_tap_s) begin
            mac_en <= 1'b1;
            mac_x  <= delay_r[rd_addr_s];
            mac_b  <= coef_sel_s;
          end
        end
        DRAIN: begin
          if (drain_done_s) begin
            out_data  <= mac_acc;
            out_valid <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_take_s) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer with a behavioural MAC model;
// stimulus pushes expected results, a negedge monitor pops and compares.
module tb_fir_tap_sequencer;
  localparam int TAPS = 16, ADDR_W = 4, DATA_W = 16, ACC_W = 39, MAC_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample = '0;
  logic              coef_we = 1'b0;
  logic [ADDR_W-1:0] coef_addr = '0;
  logic [DATA_W-1:0] coef_data = '0;
  logic              mac_en, mac_clear;
  logic [DATA_W-1:0] mac_x, mac_b;
  logic [ACC_W-1:0]  mac_acc;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;

  int n_checks = 0;
  int n_fail = 0;
  int mac_en_cnt = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] acc_m = '0;

  fir_tap_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mac_en(mac_en), .mac_clear(mac_clear), .mac_x(mac_x), .mac_b(mac_b), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  always #5 clk = ~clk;

  // MAC model with MAC_LAT = 1: mac_acc is the accumulator register itself
  always @(posedge clk) begin
    if (mac_en) acc_m <= mac_clear ? ACC_W'(mac_x) * ACC_W'(mac_b) : acc_m + ACC_W'(mac_x) * ACC_W'(mac_b);
  end
  assign mac_acc = acc_m;

  always @(negedge clk) begin
    if (mac_en) mac_en_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the posedge following a negedge with valid&ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output actual=%0h expected=none", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wr_coef(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] x, input logic [ACC_W-1:0] e, input bit push, input bit timing);
    int n;
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sample = x;
    ok = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL accept_timeout actual=0 expected=1"); end
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; mac_en_cnt = 0;
    if (timing) begin
      ok = 1'b0;
      for (n = 1; n <= 100; n++) begin
        @(posedge clk); #1;
        if (out_valid) begin ok = 1'b1; break; end
      end
      chk("latency_edges", 64'(n), 64'(17));
      chk("mac_en_cycles", 64'(mac_en_cnt), 64'(16));
    end
  endtask

  task automatic drain_q();
    int n;
    for (n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [ACC_W-1:0] full;
    int n;
    full = 39'h0FFFE0001;

    // 1. reset and idle
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mac_en", 64'(mac_en), 64'(0));
    chk("rst_mac_clear", 64'(mac_clear), 64'(0));
    chk("rst_mac_x", 64'(mac_x), 64'(0));
    chk("rst_mac_b", 64'(mac_b), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    mac_en_cnt = 0;
    repeat (50) @(negedge clk);
    chk("idle_no_mac_en", 64'(mac_en_cnt), 64'(0));

    // 2. impulse through coef[k] = k+1
    for (int k = 0; k < TAPS; k++) wr_coef(ADDR_W'(k), DATA_W'(k + 1));
    send(16'd1, 39'd1, 1'b1, 1'b1);
    for (int i = 2; i <= 16; i++) send(16'd0, ACC_W'(i), 1'b1, 1'b1);
    send(16'd0, 39'd0, 1'b1, 1'b1);
    drain_q();

    // 3. full scale
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(ADDR_W'(k), 16'hFFFF);
    for (int i = 1; i <= 16; i++) send(16'hFFFF, ACC_W'(i) * full, 1'b1, 1'b0);
    drain_q();

    // 4. wrap-around with unit coefficients
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(ADDR_W'(k), 16'd1);
    for (int i = 1; i <= 20; i++)
      send(DATA_W'(i), (i <= 16) ? ACC_W'(i * (i + 1) / 2) : ACC_W'(16 * i - 120), 1'b1, 1'b0);
    drain_q();

    // 5. backpressure on the output
    do_reset();
    wr_coef(4'd0, 16'd2);
    out_ready = 1'b0;
    send(16'd9, 39'd18, 1'b1, 1'b0);
    for (n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    chk("bp_out_valid_rise", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b1; in_sample = 16'hAAAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_out_data", 64'(out_data), 64'(18));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_mac_en", 64'(mac_en), 64'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    chk("bp_release_out_valid", 64'(out_valid), 64'(0));
    drain_q();

    // 6. reset in the middle of ISSUE
    @(posedge clk); #1;
    in_valid = 1'b1; in_sample = 16'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_mac_en", 64'(mac_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_mac_en", 64'(mac_en), 64'(0));
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_coef(4'd0, 16'd3);
    send(16'd7, 39'd21, 1'b1, 1'b1);
    drain_q();

    repeat (25) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
